gray_count_monitor: RTL and testbench

Consumer stage for a Gray-coded count stream such as a free-running Gray code counter. It samples the Gray word, optionally through a 2-flop synchronizer, and decodes it to binary. Each new sample is classified against the previous one as hold, legal +1 step, or illegal jump. A lock state machine reports stream health, and a saturating error counter supports debug.

---
 rtl/gray_mon_pkg.sv | 32 +++
 rtl/gray_sync.sv | 32 +++
 rtl/gray_count_monitor.sv | 152 +++++++++++++++
 tb/tb_gray_count_monitor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/gray_mon_pkg.sv
// Shared types and helpers for the Gray-coded count monitor.
// Build option: define GRAY_MON_SYNC_EN to put a 2-flop synchronizer in front of the decoder.
package gray_mon_pkg;

  localparam int ERR_CNT_W  = 8;
  localparam int GOOD_CNT_W = 4;
  localparam int GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED,
    FAULT
  } gray_mon_state_e;

  typedef enum logic [1:0] {
    CLS_HOLD,
    CLS_STEP,
    CLS_BAD
  } gray_mon_cls_e;

  // Callers zero-extend narrower words; the zero upper bits leave the prefix XOR unchanged.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Two-flop synchronizer for a Gray-coded bus crossing into the clk domain.
// Instantiated by gray_count_monitor only when GRAY_MON_SYNC_EN is defined.
module gray_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  logic [WIDTH-1:0] sync1_d, sync1_q;
  logic [WIDTH-1:0] sync2_d, sync2_q;

  always_comb begin
    sync1_d = d_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign d_out = sync2_q;

endmodule

// File: rtl/gray_count_monitor.sv
// Samples a Gray-coded count, decodes it, classifies each sample as hold/step/bad and tracks lock.
// Build option: GRAY_MON_SYNC_EN inserts gray_sync ahead of the decoder (two extra cycles latency).
module gray_count_monitor
  import gray_mon_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int LOCK_COUNT = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] gray_in,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] bin_out,
  output logic                  bin_valid,
  output logic                  step,
  output logic                  locked,
  output logic                  err_pulse,
  output logic [ERR_CNT_W-1:0]  err_count
);

  localparam logic [ERR_CNT_W-1:0]  ERR_MAX  = {ERR_CNT_W{1'b1}};
  localparam logic [GOOD_CNT_W-1:0] LOCK_CNT = GOOD_CNT_W'(LOCK_COUNT);

  logic [DATA_WIDTH-1:0] gray_s;
  logic [DATA_WIDTH-1:0] sample_bin;
  logic [DATA_WIDTH-1:0] next_bin;
  gray_mon_cls_e         cls;

  gray_mon_state_e       state_d,     state_q;
  logic [GOOD_CNT_W-1:0] good_cnt_d,  good_cnt_q;
  logic [GOOD_CNT_W-1:0] good_inc;
  logic [DATA_WIDTH-1:0] bin_d,       bin_q;
  logic                  bin_valid_d, bin_valid_q;
  logic                  step_d,      step_q;
  logic                  locked_d,    locked_q;
  logic                  err_pulse_d, err_pulse_q;
  logic [ERR_CNT_W-1:0]  err_count_d, err_count_q;

`ifdef GRAY_MON_SYNC_EN
  gray_sync #(
    .WIDTH (DATA_WIDTH)
  ) u_gray_sync (
    .clk    (clk),
    .resetn (resetn),
    .d_in   (gray_in),
    .d_out  (gray_s)
  );
`else
  assign gray_s = gray_in;
`endif

  assign sample_bin = DATA_WIDTH'(gray2bin(GRAY_MAX_W'(gray_s)));
  assign next_bin   = bin_q + DATA_WIDTH'(1);
  assign good_inc   = good_cnt_q + GOOD_CNT_W'(1);

  // The +1 compare wraps naturally, so all-ones -> 0 is a legal step.
  always_comb begin
    cls = CLS_BAD;
    if (sample_bin == bin_q) begin
      cls = CLS_HOLD;
    end else if (sample_bin == next_bin) begin
      cls = CLS_STEP;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves a latch behind.
  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    bin_d       = sample_bin;
    bin_valid_d = bin_valid_q;
    step_d      = 1'b0;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;

    case (state_q)
      IDLE: begin
        bin_valid_d = 1'b1;
        good_cnt_d  = '0;
        state_d     = ACQUIRE;
      end
      ACQUIRE: begin
        if (cls == CLS_STEP) begin
          good_cnt_d = good_inc;
          if (good_inc == LOCK_CNT) begin
            state_d = LOCKED;
          end
        end else if (cls == CLS_BAD) begin
          good_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (cls == CLS_BAD) begin
          state_d = FAULT;
        end
      end
      FAULT: begin
        if (cls == CLS_STEP) begin
          good_cnt_d = GOOD_CNT_W'(1);
          state_d    = (LOCK_COUNT == 1) ? LOCKED : ACQUIRE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The IDLE capture has no previous sample to compare against.
    if (state_q != IDLE) begin
      step_d      = (cls == CLS_STEP);
      err_pulse_d = (cls == CLS_BAD);
    end

    // A clear coinciding with an error leaves that error counted.
    if (clear_err) begin
      err_count_d = err_pulse_d ? ERR_CNT_W'(1) : '0;
    end else if (err_pulse_d && (err_count_q != ERR_MAX)) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end

    locked_d = (state_d == LOCKED);
  end

  // NOTE: reset is sampled on the clock edge and all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      good_cnt_q  <= '0;
      bin_q       <= '0;
      bin_valid_q <= 1'b0;
      step_q      <= 1'b0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      bin_q       <= bin_d;
      bin_valid_q <= bin_valid_d;
      step_q      <= step_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign bin_out   = bin_q;
  assign bin_valid = bin_valid_q;
  assign step      = step_q;
  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_gray_count_monitor.sv
// Scoreboard bench for gray_count_monitor: the driver queues expected outputs, a monitor compares them.
// Works in both builds; GRAY_MON_SYNC_EN only changes the expected latency.
module tb_gray_count_monitor;

  localparam int W = 4;
`ifdef GRAY_MON_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int           due;
    string        name;
    logic [W-1:0] bin;
    logic         valid;
    logic         step;
    logic         err;
    logic         locked;
    logic [7:0]   ecnt;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetn;
  logic [W-1:0] gray_in;
  logic         clear_err;
  logic [W-1:0] bin_out;
  logic         bin_valid;
  logic         step;
  logic         locked;
  logic         err_pulse;
  logic [7:0]   err_count;

  exp_t       sb_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [2:0] clr_hist = '0;

  gray_count_monitor #(
    .DATA_WIDTH (W),
    .LOCK_COUNT (2)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .gray_in   (gray_in),
    .clear_err (clear_err),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .step      (step),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // clear_err is delayed so that it meets the classification of the vector it was issued with.
  task automatic shift_clr(input logic clr);
    clr_hist  = {clr_hist[1:0], clr};
    clear_err = clr_hist[LAT-1];
  endtask

  task automatic apply(input int b, input logic clr, input logic es, input logic ee,
                       input logic el, input int ec, input string nm);
    exp_t         r;
    logic [W-1:0] bb;
    bb      = W'(b);
    gray_in = bb ^ (bb >> 1);
    shift_clr(clr);
    r.due    = cyc + LAT;
    r.name   = nm;
    r.bin    = bb;
    r.valid  = 1'b1;
    r.step   = es;
    r.err    = ee;
    r.locked = el;
    r.ecnt   = 8'(ec);
    sb_q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    shift_clr(1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 16) begin
      idle_cycle();
      n++;
    end
    check("drain_pending", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic do_reset(input int n);
    exp_t r;
    resetn    = 1'b0;
    gray_in   = '0;
    clr_hist  = '0;
    clear_err = 1'b0;
    r.due    = cyc + 1;
    r.name   = "reset";
    r.bin    = '0;
    r.valid  = 1'b0;
    r.step   = 1'b0;
    r.err    = 1'b0;
    r.locked = 1'b0;
    r.ecnt   = '0;
    sb_q.push_back(r);
    repeat (n) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Monitor: pops every expectation whose cycle has arrived and compares on the falling edge.
  initial begin
    exp_t r;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        r = sb_q.pop_front();
        check({r.name, ".due"}, cyc, r.due);
        check({r.name, ".bin_out"},   bin_out,   r.bin);
        check({r.name, ".bin_valid"}, bin_valid, r.valid);
        check({r.name, ".step"},      step,      r.step);
        check({r.name, ".err_pulse"}, err_pulse, r.err);
        check({r.name, ".locked"},    locked,    r.locked);
        check({r.name, ".err_count"}, err_count, r.ecnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn    = 1'b0;
    gray_in   = '0;
    clear_err = 1'b0;
    do_reset(2);

    // First capture and holds at zero
    repeat (3) apply(0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "hold0");

    // Gray 0,1,3,2: lock on the second step
    apply(1, 1'b0, 1'b1, 1'b0, 1'b0, 0, "step1");
    apply(2, 1'b0, 1'b1, 1'b0, 1'b1, 0, "step2_lock");
    apply(3, 1'b0, 1'b1, 1'b0, 1'b1, 0, "step3");
    for (int b = 4; b < 16; b++) apply(b, 1'b0, 1'b1, 1'b0, 1'b1, 0, "run");

    // Wrap Gray 8 (bin 15) -> 0
    apply(0, 1'b0, 1'b1, 1'b0, 1'b1, 0, "wrap");
    for (int b = 1; b <= 5; b++) apply(b, 1'b0, 1'b1, 1'b0, 1'b1, 0, "run2");

    // Jump bin 5 -> 8 (Gray 0xC), then recover through ACQUIRE
    apply(8, 1'b0, 1'b0, 1'b1, 1'b0, 1, "jump");
    apply(9, 1'b0, 1'b1, 1'b0, 1'b0, 1, "acquire");
    apply(10, 1'b0, 1'b1, 1'b0, 1'b1, 1, "relock");
    apply(10, 1'b0, 1'b0, 1'b0, 1'b1, 1, "hold_locked");

    // 260 backward steps saturate the error counter
    for (int n = 1; n <= 260; n++) begin
      apply((10 - n + 320) % 16, 1'b0, 1'b0, 1'b1, 1'b0, (n + 1 > 255) ? 255 : n + 1, "back");
    end
    apply(5, 1'b1, 1'b0, 1'b1, 1'b0, 1, "clr_with_bad");
    apply(4, 1'b0, 1'b0, 1'b1, 1'b0, 2, "bad_after_clr");
    apply(4, 1'b1, 1'b0, 1'b0, 1'b0, 0, "clr_on_hold");
    apply(5, 1'b0, 1'b1, 1'b0, 1'b0, 0, "fault_step");
    apply(6, 1'b0, 1'b1, 1'b0, 1'b1, 0, "relock2");

    // Reset while locked, then capture and relock
    drain();
    do_reset(1);
    apply(0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "post_rst_capture");
    apply(1, 1'b0, 1'b1, 1'b0, 1'b0, 0, "post_rst_step1");
    apply(2, 1'b0, 1'b1, 1'b0, 1'b1, 0, "post_rst_lock");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
